// File: rtl/logic_op_pkg.sv
// Shared constants and types for the logic-op arbiter slice.
// Opcode encodings, opcode width and FSM state type.
package logic_op_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_AND  = 3'd0;
  localparam logic [OPW-1:0] OP_NAND = 3'd1;
  localparam logic [OPW-1:0] OP_OR   = 3'd2;
  localparam logic [OPW-1:0] OP_NOR  = 3'd3;
  localparam logic [OPW-1:0] OP_XOR  = 3'd4;
  localparam logic [OPW-1:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Shared two-operand bitwise gate unit.
// Purely combinational; codes 6/7 yield zero with err set.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    unique case (1'b1)
      (op == OP_AND):  y = a & b;
      (op == OP_NAND): y = ~(a & b);
      (op == OP_OR):   y = a | b;
      (op == OP_NOR):  y = ~(a | b);
      (op == OP_XOR):  y = a ^ b;
      (op == OP_XNOR): y = ~(a ^ b);
      default:         err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin front end sharing one logic_op_unit among NREQ clients.
// Three-state flow: capture (IDLE), evaluate (EXEC), hold result (RESP).
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err
);

  // First valid requester strictly after last, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(
    input logic [NREQ-1:0] v,
    input logic [IDW-1:0]  last
  );
    logic [IDW-1:0] g;
    logic           hit;
    int             idx;
    g   = '0;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!hit && v[idx]) begin
        hit = 1'b1;
        g   = idx[IDW-1:0];
      end
    end
    return g;
  endfunction

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             err_q, err_d;

  logic             any_v;
  logic [IDW-1:0]   grant;
  logic [WIDTH-1:0] u_y;
  logic             u_err;

  assign any_v = |req_valid;
  assign grant = rr_pick(req_valid, last_q);

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && any_v)
      req_ready[grant] = 1'b1;
  end

  logic_op_unit #(.WIDTH(WIDTH)) u_unit (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .y   (u_y),
    .err (u_err)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    y_d     = y_q;
    id_d    = id_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (any_v) begin
          a_d     = req_a[grant*WIDTH +: WIDTH];
          b_d     = req_b[grant*WIDTH +: WIDTH];
          op_d    = req_op[grant*OPW +: OPW];
          gid_d   = grant;
          state_d = EXEC;
        end
      end
      EXEC: begin
        y_d     = u_y;
        err_d   = u_err;
        id_d    = gid_q;
        last_d  = gid_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      gid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      y_q     <= y_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_y     = y_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter (NREQ=4, WIDTH=8).
// Hand-computed expectations checked with immediate assertions.
module tb_logic_op_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*3-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_y;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;

  int total = 0;
  int bad   = 0;

  logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op);
    req_a[id*8 +: 8]  = a;
    req_b[id*8 +: 8]  = b;
    req_op[id*3 +: 3] = op;
    req_valid[id]     = 1'b1;
  endtask

  // Grant check, accept edge, EXEC, RESP check, handshake edge.
  task automatic serve(input int id, input logic [7:0] ey,
                       input logic ee, input bit drop);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    #1;
    chk("grant", 32'(req_ready), 32'(oh));
    step();
    if (drop) req_valid[id] = 1'b0;
    #1;
    chk("exec_valid", 32'(rsp_valid), 0);
    chk("exec_ready", 32'(req_ready), 0);
    step();
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_y", 32'(rsp_y), 32'(ey));
    chk("rsp_id", 32'(rsp_id), id);
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("resp_ready", 32'(req_ready), 0);
    step();
    chk("post_valid", 32'(rsp_valid), 0);
  endtask

  logic [7:0] tbl [8];

  initial begin
    tbl[0] = 8'h0A; tbl[1] = 8'hF5; tbl[2] = 8'hAF; tbl[3] = 8'h50;
    tbl[4] = 8'hA5; tbl[5] = 8'h5A; tbl[6] = 8'h00; tbl[7] = 8'h00;

    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_y", 32'(rsp_y), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_err", 32'(rsp_err), 0);
    req_valid = '0;
    rst_n     = 1'b1;
    step();
    chk("idle_ready", 32'(req_ready), 0);

    set_req(0, 8'hF0, 8'h3C, 3'd4);
    serve(0, 8'hCC, 1'b0, 1'b1);

    for (int op = 0; op < 8; op++) begin
      set_req(0, 8'hAA, 8'h0F, op[2:0]);
      serve(0, tbl[op], op >= 6, 1'b1);
    end

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      set_req(i, 8'hAA, 8'h0F, i[2:0]);
    for (int n = 0; n < 6; n++)
      serve(n % 4, tbl[n % 4], 1'b0, 1'b0);
    req_valid = '0;

    // last grant is 1; only requester 2 -> 2, held under backpressure
    set_req(2, 8'h33, 8'h55, 3'd2);
    #1;
    chk("bp_grant", 32'(req_ready), 32'h4);
    step();
    req_valid[2] = 1'b0;
    set_req(0, 8'h01, 8'h01, 3'd0);
    rsp_ready = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_y", 32'(rsp_y), 32'h77);
      chk("bp_id", 32'(rsp_id), 2);
      chk("bp_ready", 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_last_valid", 32'(rsp_valid), 1);
    step();
    chk("bp_done", 32'(rsp_valid), 0);
    chk("bp_next_grant", 32'(req_ready), 32'h1);
    req_valid = '0;

    set_req(1, 8'hFF, 8'h0F, 3'd0);
    #1;
    chk("mid_grant", 32'(req_ready), 32'h2);
    step();
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mid_valid", 32'(rsp_valid), 0);
    chk("mid_y", 32'(rsp_y), 0);
    chk("mid_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    step();
    step();
    chk("mid_no_rsp", 32'(rsp_valid), 0);
    set_req(2, 8'hC3, 8'h0F, 3'd3);
    serve(2, 8'h30, 1'b0, 1'b1);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(1, 8'h12, 8'h34, 3'd2);
    serve(1, 8'h36, 1'b0, 1'b1);
    set_req(1, 8'hF0, 8'hFF, 3'd5);
    set_req(3, 8'h0F, 8'hFF, 3'd1);
    serve(3, 8'hF0, 1'b0, 1'b1);
    serve(1, 8'hF0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one WIDTH-bit two-operand logic-gate unit (AND, NAND, OR, NOR, XOR, XNOR) between NREQ requesters.
- Round-robin arbitration picks one requester. The block captures its operands and opcode, evaluates them in the shared unit and returns a registered result tagged with the requester ID.
- It sits between several client blocks and the team's bitwise gate datapath. It serializes use of that datapath and applies valid/ready flow control on both sides.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- IDW, $clog2(NREQ), requester ID width (derived; do not override).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- req_valid  input  NREQ  bit i = requester i has an operation pending.
- req_ready  output  NREQ  one-hot grant/accept; bit i high = requester i's operation captured this cycle.
- req_a  input  NREQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same slicing.
- req_op  input  NREQ*3  opcode; requester i uses slice [i*3 +: 3].
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_y  output  WIDTH  result.
- rsp_id  output  IDW  index of the requester that issued the operation.
- rsp_err  output  1  opcode was illegal.

Behaviour:
- Opcodes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR. Codes 6 and 7 are illegal: rsp_y=0, rsp_err=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, pick winner g = first set bit searching upward (with wrap) from last_grant+1. req_ready is combinational: req_ready[g]=1, all other bits 0.
  - On that edge, capture a, b, op and g into registers, then go to EXEC.
  - With no req_valid set, req_ready=0 and the FSM stays in IDLE.
- EXEC: the shared unit evaluates the captured operands. Register rsp_y, rsp_err and rsp_id, set last_grant=g, go to RESP. req_ready=0.
- RESP:
  - rsp_valid=1; rsp_y, rsp_id and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE and deassert rsp_valid on the next cycle.
  - req_ready=0 throughout RESP.
- Latency: accept edge at cycle t; rsp_valid is high from cycle t+2. Minimum 3 cycles per operation when rsp_ready is tied high.
- Fairness: a requester holding req_valid is served within NREQ operations.
- Requesters must hold req_valid, operands and opcode stable until they see req_ready. The arbiter must not lose a grant if req_valid drops before the grant; it simply re-arbitrates.
- Reset (rst_n low at an edge), from any state:
  - state=IDLE, last_grant=NREQ-1 (so requester 0 wins first).
  - rsp_valid=0, rsp_y=0, rsp_id=0, rsp_err=0.
  - req_ready=0 while rst_n is low.
  - An in-flight operation is discarded with no response.
- Width rules: the gate operations are purely bitwise per bit; no carries.
- IDW is at least 1 when NREQ=2.

Decomposition:
- Package logic_op_pkg holds:
  - the 3-bit opcode constants OP_AND..OP_XNOR;
  - the state enum IDLE/EXEC/RESP;
  - the opcode width constant (3).
- Sub-module logic_op_unit:
  - combinational, WIDTH-parameterized;
  - inputs a, b, op; outputs y, err;
  - instantiated once inside the arbiter.
- Round-robin selection is a function inside the arbiter; it needs no separate module.

Test Plan:
- Reset then single request: requester 0 sends a=8'hF0, b=8'h3C, op=4 (XOR) with rsp_ready=1 → req_ready[0] on the accept cycle; rsp_valid two cycles later with rsp_y=8'hCC, rsp_id=0, rsp_err=0.
- All opcodes: a=8'hAA, b=8'h0F, op 0..5 → rsp_y=0A, F5, AF, 50, A5, 5A respectively. op=6 → rsp_y=00, rsp_err=1.
- Round-robin: all four req_valid held high continuously → grant order 0,1,2,3,0,1; each rsp_id matches its grant.
- Backpressure: rsp_ready low for 5 cycles during RESP → rsp_valid, rsp_y and rsp_id stay stable; req_ready stays 0; completes on the first rsp_ready=1 cycle.
- Reset mid-operation: rst_n low during EXEC → rsp_valid=0 and state IDLE after that edge; the next request from requester 2 is granted first as requester 0 is idle, and the subsequent response is correct.
- Sparse requests: only requesters 1 and 3 valid, with last_grant=1 → requester 3 is granted next, then requester 1.
